// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and taken-branch flushes, stretched by a small FSM.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_ctrl #(
    parameter int LOAD_STALLS  = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             br_taken,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALLS - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         STALL_MULTI  = (LOAD_STALLS > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       hz_s;

    assign hz_s = ex_mem_read & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign state = state_r;

    // FSM state and stretch counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and combinational pipeline controls; a branch overrides any state
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        pc_sel      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nxt_s = RUN;
            cnt_nxt_s   = 4'd0;
        end else if (br_taken) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (FLUSH_MULTI) begin
                state_nxt_s = FLUSH;
                cnt_nxt_s   = FLUSH_RELOAD;
            end else begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 4'd0;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (hz_s) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                        if (STALL_MULTI) begin
                            state_nxt_s = STALL;
                            cnt_nxt_s   = STALL_RELOAD;
                        end else begin
                            state_nxt_s = RUN;
                            cnt_nxt_s   = 4'd0;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                STALL: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    cnt_nxt_s  = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    cnt_nxt_s  = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = FLUSH;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_ev_s;
    logic             br_ev_s;

    // Outside reset, pc_we low only ever comes from a load stall and pc_sel only from a branch
    assign stall_ev_s = ~rst & ~pc_we;
    assign br_ev_s    = ~rst & pc_sel;

    // Saturating statistics counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (br_ev_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (1-cycle stall/flush and 3-stall/2-flush/4-bit counters)
// share the same stimulus; counter expectations follow HAZARD_STATS_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Packed view: {pc_we, ifid_we, pc_sel, ifid_flush, idex_flush, exmem_flush, state[1:0]}
    localparam logic [7:0] NORM   = 8'b1100_0000;
    localparam logic [7:0] RSTV   = 8'b0001_1100;
    localparam logic [7:0] STL0   = 8'b0000_1000;
    localparam logic [7:0] STL1   = 8'b0000_1001;
    localparam logic [7:0] BR_RUN = 8'b1111_1100;
    localparam logic [7:0] BR_STL = 8'b1111_1101;
    localparam logic [7:0] BR_FLS = 8'b1111_1110;
    localparam logic [7:0] FLS    = 8'b1101_1010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_uses_rt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_rt = 5'd0;
    logic       br_taken = 1'b0;

    logic        a_pc_we, a_pc_sel, a_ifid_we, a_ifid_flush, a_idex_flush, a_exmem_flush;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_we, b_pc_sel, b_ifid_we, b_ifid_flush, b_idex_flush, b_exmem_flush;
    logic [1:0]  b_state;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .br_taken(br_taken),
        .pc_we(a_pc_we), .pc_sel(a_pc_sel), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush), .state(a_state),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.LOAD_STALLS(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .br_taken(br_taken),
        .pc_we(b_pc_we), .pc_sel(b_pc_sel), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush), .state(b_state),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
        chk({tag, "_a"}, {24'd0, a_pc_we, a_ifid_we, a_pc_sel, a_ifid_flush,
                          a_idex_flush, a_exmem_flush, a_state}, {24'd0, exp_a});
        chk({tag, "_b"}, {24'd0, b_pc_we, b_ifid_we, b_pc_sel, b_ifid_flush,
                          b_idex_flush, b_exmem_flush, b_state}, {24'd0, exp_b});
    endtask

    task automatic chk_cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
        chk({tag, "_stall_a"}, {16'd0, a_stall_cnt}, STATS ? 32'(sa) : 32'd0);
        chk({tag, "_flush_a"}, {16'd0, a_flush_cnt}, STATS ? 32'(fa) : 32'd0);
        chk({tag, "_stall_b"}, {28'd0, b_stall_cnt}, STATS ? 32'(sb) : 32'd0);
        chk({tag, "_flush_b"}, {28'd0, b_flush_cnt}, STATS ? 32'(fb) : 32'd0);
    endtask

    task automatic drive(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br);
        @(negedge clk);
        ex_mem_read = rd;
        ex_rt       = ert;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = urt;
        br_taken    = br;
        #1;
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("reset", RSTV, RSTV);
        chk_cnt("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("release", NORM, NORM);

        // load-use on rs
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rs_c1", STL0, STL0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rs_c2", NORM, STL1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rs_c3", NORM, STL1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rs_c4", NORM, NORM);
        chk_cnt("hz_rs", 1, 0, 3, 0);

        // load-use on rt with id_uses_rt
        drive(1'b1, 5'd9, 5'd7, 5'd9, 1'b1, 1'b0); chk_ctl("hz_rt_c1", STL0, STL0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rt_c2", NORM, STL1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rt_c3", NORM, STL1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("hz_rt_c4", NORM, NORM);
        chk_cnt("hz_rt", 2, 0, 6, 0);

        // near-misses: rt not used, r0 destination, not a load
        drive(1'b1, 5'd9, 5'd7, 5'd9, 1'b0, 1'b0); chk_ctl("no_use_rt", NORM, NORM);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); chk_ctl("ex_rt_zero", NORM, NORM);
        drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk_ctl("no_load", NORM, NORM);
        chk_cnt("no_hz", 2, 0, 6, 0);

        // taken branch pulse
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk_ctl("br_c1", BR_RUN, BR_RUN);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("br_c2", NORM, FLS);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("br_c3", NORM, NORM);
        chk_cnt("br", 2, 1, 6, 1);

        // branch and hazard together: branch wins
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1); chk_ctl("brhz_c1", BR_RUN, BR_RUN);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("brhz_c2", NORM, FLS);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("brhz_c3", NORM, NORM);
        chk_cnt("brhz", 2, 2, 6, 2);

        // branch arriving during a multi-cycle stall
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk_ctl("brstl_c1", STL0, STL0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk_ctl("brstl_c2", BR_RUN, BR_STL);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("brstl_c3", NORM, FLS);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("brstl_c4", NORM, NORM);
        chk_cnt("brstl", 3, 3, 7, 3);

        // reset in cycle 2 of a 3-cycle stall
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); chk_ctl("rststl_c1", STL0, STL0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("rststl_c2", NORM, STL1);
        chk_cnt("rststl", 4, 3, 8, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_ctl("rst_mid", RSTV, RSTV);
        chk_cnt("rst_mid", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("rst_rel", NORM, NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("rst_idle", NORM, NORM);

        // 20 back-to-back branches: reload in FLUSH, counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            chk_ctl("sat_br", BR_RUN, (i == 0) ? BR_RUN : BR_FLS);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("sat_c1", NORM, FLS);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk_ctl("sat_c2", NORM, NORM);
        chk_cnt("sat", 0, 20, 0, 15);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage datapath. It detects load-use hazards between the IF/ID and ID/EX buffers, and branch redirects resolved in the EX/MEM stage. It drives the PC write enable, the IF/ID write enable and per-buffer flush (bubble) signals. A small FSM with a down-counter stretches stalls and flushes for configurable memory latency and branch penalty.

## Interface
- `LOAD_STALLS`, default 1: stall cycles per load-use hazard. Legal range 1..15.
- `FLUSH_CYCLES`, default 1: cycles IF/ID and ID/EX stay flushed after a taken branch. Legal range 1..15.
- `CNT_W`, default 16: width of the statistics counters.

- `clk` in 1: rising-edge clock shared with all pipeline buffers.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in IF/ID.
- `id_rt` in 5: rt field of the instruction in IF/ID.
- `id_uses_rt` in 1: the IF/ID instruction reads rt as a source (R-type, branch, store).
- `ex_mem_read` in 1: load bit of the M control field held in ID/EX.
- `ex_rt` in 5: load destination register held in ID/EX.
- `br_taken` in 1: taken branch resolved in EX/MEM this cycle.
- `pc_we` out 1: PC register write enable.
- `pc_sel` out 1: 1 selects the branch target into PC.
- `ifid_we` out 1: IF/ID buffer write enable.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `idex_flush` out 1: clear the WB/M/EX control fields of ID/EX (bubble).
- `exmem_flush` out 1: clear the control fields of EX/MEM.
- `state` out 2: FSM state. RUN=0, STALL=1, FLUSH=2.
- `stall_cnt` out CNT_W: load-stall cycle count (see Configuration).
- `flush_cnt` out CNT_W: taken-branch event count (see Configuration).

## Operation
- Hazard term: `hz = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.
- Outputs are combinational from the state and the inputs, so they take effect in the same cycle the pipeline buffers sample.
- **RUN state**, priority order:
  - **`br_taken`:** `pc_sel=1`, `pc_we=1`, `ifid_we=1`, `ifid_flush=1`, `idex_flush=1`, `exmem_flush=1`. If `FLUSH_CYCLES>1`, go to FLUSH with `cnt=FLUSH_CYCLES-1`; otherwise stay in RUN.
  - **`hz` (no branch):** `pc_we=0`, `ifid_we=0`, `idex_flush=1`. If `LOAD_STALLS>1`, go to STALL with `cnt=LOAD_STALLS-1`; otherwise stay in RUN.
  - **Neither:** `pc_we=1`, `ifid_we=1`, all flushes 0, `pc_sel=0`.
- **STALL state:**
  - Outputs: `pc_we=0`, `ifid_we=0`, `idex_flush=1`. `hz` is ignored.
  - `cnt` decrements each cycle; at `cnt==1` the next state is RUN.
  - `br_taken` in STALL takes RUN branch behaviour this cycle and overrides the stall. The next state follows the RUN branch rule.
- **FLUSH state:**
  - Outputs: `pc_we=1`, `ifid_we=1`, `ifid_flush=1`, `idex_flush=1`, `exmem_flush=0`, `pc_sel=0`.
  - `hz` is ignored. A new `br_taken` reloads `cnt=FLUSH_CYCLES-1` and applies the full branch outputs.
  - `cnt` decrements; at `cnt==1` the next state is RUN.
- `cnt` is 4 bits. It never wraps because it is reloaded only with a value ≥1 and exits at 1.

## Timing
- Hazard detection to stall: 0 cycles (same cycle).
- Total stall per load-use hazard: exactly `LOAD_STALLS` cycles with `pc_we=0`.
- Branch penalty: `FLUSH_CYCLES` cycles of `ifid_flush`/`idex_flush`, plus one cycle of `exmem_flush`.
- **During `rst` high:** `state`=RUN, `cnt`=0, `pc_we=0`, `ifid_we=0`, `pc_sel=0`, `ifid_flush=1`, `idex_flush=1`, `exmem_flush=1`, `stall_cnt=0`, `flush_cnt=0`.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence immediately and asynchronously.
- The first rising edge after `rst` falls evaluates from RUN.
- Simultaneous `br_taken` and `hz`: the branch wins, and no stall cycle is counted.

## Configuration
- Macro: `HAZARD_STATS_EN`.
- **Defined:**
  - `stall_cnt` increments on every cycle with `pc_we=0` caused by a load stall.
  - `flush_cnt` increments once per accepted `br_taken`.
  - Both counters saturate at `2^CNT_W-1` and clear only on `rst`.
- **Undefined:** both ports remain present, tied to 0, and no counter flops are inferred.

## Test plan
- **Load-use on rs, `LOAD_STALLS=1`:** `ex_mem_read=1`, `ex_rt=5`, `id_rs=5` for one cycle → `pc_we=0`, `ifid_we=0`, `idex_flush=1` for exactly 1 cycle, `state` stays 0, `stall_cnt=1`.
- **`LOAD_STALLS=3`, hazard on rt with `id_uses_rt=1`:** → `pc_we=0` for 3 consecutive cycles, `state` sequence 0,1,1,0, `stall_cnt=3`. Same stimulus with `id_uses_rt=0` → no stall. `ex_rt=0` → no stall.
- **`FLUSH_CYCLES=2`, `br_taken` pulse in RUN:** → cycle 1: `pc_sel=1` and all three flushes; cycle 2: `ifid_flush=idex_flush=1`, `exmem_flush=0`, `pc_sel=0`; then RUN. `flush_cnt=1`.
- **`br_taken` and `hz` asserted together:** → branch outputs only, `pc_we=1`, `stall_cnt` unchanged.
- **`rst` raised in cycle 2 of a 3-cycle STALL:** → outputs go to reset values immediately. After release with idle inputs: `pc_we=1`, `ifid_we=1`, `state=0`.
- **`CNT_W=4` with `HAZARD_STATS_EN` defined, 20 branches:** → `flush_cnt=15`, saturated. Without the macro → `flush_cnt=0`.
